// File: rtl/nibble_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : nibble_accumulator
// Purpose  : Frame accumulator closing the loop around an external 4-bit
//            adder; reports per-frame sum, sticky overflow and beat count.
// Revision : 1.0  initial release
// ============================================================================
module nibble_accumulator #(
   parameter int MAX_ITEMS = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_data,
   input  logic       in_last,
   output logic [3:0] add_a,
   output logic [3:0] add_b,
   input  logic [3:0] add_s,
   input  logic       add_c4,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_sum,
   output logic       out_ovf,
   output logic [3:0] out_count
);

   localparam logic [0:0] c_st_acc    = 1'b0;
   localparam logic [0:0] c_st_done   = 1'b1;
   localparam logic [3:0] c_max_items = 4'(MAX_ITEMS);

   logic [0:0] r_state;
   logic [3:0] r_acc;
   logic       r_ovf;
   logic [3:0] r_cnt;

   logic       w_accept;
   logic [3:0] w_cnt_next;
   logic       w_close;

   // rst_n is active-high despite its name; hold off beats while it is set
   assign in_ready   = (r_state == c_st_acc) & ~rst_n;
   assign w_accept   = in_valid & in_ready;
   assign w_cnt_next = r_cnt + 4'd1;
   assign w_close    = in_last | (w_cnt_next == c_max_items);

   assign add_a     = r_acc;
   assign add_b     = (r_state == c_st_acc) ? in_data : 4'h0;

   assign out_valid = (r_state == c_st_done);
   assign out_sum   = r_acc;
   assign out_ovf   = r_ovf;
   assign out_count = r_cnt;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_state <= c_st_acc;
         r_acc   <= 4'h0;
         r_ovf   <= 1'b0;
         r_cnt   <= 4'h0;
      end else begin
         case (r_state)
            c_st_acc: begin
               if (w_accept) begin
                  r_acc <= add_s;
                  r_ovf <= r_ovf | add_c4;
                  r_cnt <= w_cnt_next;
                  if (w_close) begin
                     r_state <= c_st_done;
                  end
               end
            end
            c_st_done: begin
               if (out_ready) begin
                  r_acc   <= 4'h0;
                  r_ovf   <= 1'b0;
                  r_cnt   <= 4'h0;
                  r_state <= c_st_acc;
               end
            end
            default: r_state <= c_st_acc;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/nibble_accumulator.md
# nibble_accumulator

Frame accumulator that sits directly upstream of the 4-bit ripple adder and closes the loop around it. It drives the adder's A operand from its accumulator register and the B operand from the incoming data nibble. It captures the adder's S/C4 back each accepted beat and reports a per-frame sum, a sticky overflow flag and a beat count over a valid/ready output.

## Interface
Parameters:
- MAX_ITEMS, default 8: beats per frame before forced frame end; legal 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-high reset (1 = reset), sampled on rising edge of clk.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  4  data nibble.
- in_last  in  1  beat closes the current frame.
- add_a  out  4  adder operand A; always equals accumulator register.
- add_b  out  4  adder operand B; in_data in ACC state, 4'h0 otherwise.
- add_s  in  4  adder sum (combinational from add_a/add_b).
- add_c4  in  1  adder carry-out.
- out_valid  out  1  frame result valid.
- out_ready  in  1  consumer takes result.
- out_sum  out  4  frame sum mod 16.
- out_ovf  out  1  at least one beat of the frame produced add_c4 = 1.
- out_count  out  4  beats accepted in the frame.

## Operation
- Two states: ACC and DONE. Registers: acc[3:0], ovf, cnt[3:0], state.
- Reset (rst_n = 1 at an edge): state <= ACC, acc/ovf/cnt <= 0. Any frame in progress is discarded, with no output produced.
- ACC:
  - in_ready = 1, out_valid = 0.
  - Accept = in_valid & in_ready. On accept: acc <= add_s, ovf <= ovf | add_c4, cnt <= cnt + 1.
  - On accept with in_last = 1, or with cnt + 1 == MAX_ITEMS: state <= DONE.
  - No accept: all registers hold.
- DONE:
  - in_ready = 0, out_valid = 1, add_b = 0.
  - out_sum = acc, out_ovf = ovf, out_count = cnt; all are stable while out_valid & ~out_ready.
  - On out_ready = 1: acc/ovf/cnt <= 0, state <= ACC.
- Overflow is sticky within a frame. A later beat with no carry does not clear it. It clears only on result handoff or reset.
- Arithmetic is modulo 16 on acc. The block does not add carry back in; the adder's carry-in is tied 0.
- in_last together with the MAX_ITEMS-th beat ends the frame once, not twice.
- in_data and in_last are ignored when in_ready = 0.

## Timing
- in_ready and add_a/add_b are combinational from state/acc only, not from in_valid. No combinational path runs from out_ready to in_ready.
- During a reset cycle in_ready = 0 and out_valid = 0. in_ready = 1 from the first cycle after reset is released.
- All out_* signals are registered (driven from state/acc/ovf/cnt).
- Reset value of every output: in_ready 0 (during reset), out_valid 0, out_sum 0, out_ovf 0, out_count 0, add_a 0, add_b = in_data after release.
- Throughput is 1 beat/cycle inside a frame.
- Latency: if the closing beat is accepted at edge k, out_valid = 1 in cycle k+1.
- Result handoff: if out_ready = 1 at edge j, then in cycle j+1 in_ready = 1, out_valid = 0, and acc = 0.
  - Minimum frame-to-frame gap is one cycle (the DONE cycle).
- Reset asserted while in DONE overrides out_ready. The result is dropped and out_valid = 0 the next cycle.

## Test plan
- Frame 3, 4, 5 (last on 5), out_ready = 1 → one cycle after the 5 is accepted: out_valid = 1, out_sum = 0xC, out_ovf = 0, out_count = 3. In the following cycle in_ready = 1.
- Frame 9, 9 (last) → out_sum = 0x2, out_ovf = 1, out_count = 2. Next frame 1 (last) → out_sum = 0x1, out_ovf = 0 (sticky flag cleared by handoff).
- MAX_ITEMS = 8, nine beats of 0x1, in_last never set → after 8th accept: out_valid = 1, out_sum = 0x8, out_count = 8, in_ready = 0. The 9th beat is held and becomes the first beat of the next frame (out_count = 1, out_sum = 0x1 if last).
- Frame 0xF, 0x1, 0x0 (last) → carry only on beat 2: out_ovf = 1, out_sum = 0x0. Hold out_ready = 0 for 5 cycles → outputs are unchanged, in_ready = 0, and in_valid is ignored throughout.
- in_valid toggling 1/0 every cycle across frame 2, 2, 2 (last) → out_sum = 0x6, out_count = 3. add_a tracks 0, 2, 4 between beats.
- Accept 7, 7, assert rst_n = 1 for one cycle, then send 5 (last) → no output from the aborted frame. Result: out_sum = 0x5, out_ovf = 0, out_count = 1.
